// File: rtl/mem_pkg.sv
// Shared decode helpers for the MEM-stage load/store controller.
// Op3 encodings, FSM state type, access size and lane/byte-enable helpers.
package mem_pkg;

   localparam logic [1:0] OP_MEM   = 2'b11;

   localparam logic [5:0] OP3_LD   = 6'b000000;
   localparam logic [5:0] OP3_LDUB = 6'b000001;
   localparam logic [5:0] OP3_LDUH = 6'b000010;
   localparam logic [5:0] OP3_LDD  = 6'b000011;
   localparam logic [5:0] OP3_ST   = 6'b000100;
   localparam logic [5:0] OP3_STB  = 6'b000101;
   localparam logic [5:0] OP3_STH  = 6'b000110;
   localparam logic [5:0] OP3_STD  = 6'b000111;
   localparam logic [5:0] OP3_LDSB = 6'b001001;
   localparam logic [5:0] OP3_LDSH = 6'b001010;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE} size_e;

   function automatic size_e size_of(input logic [5:0] op3);
      case (op3)
         OP3_LDUB, OP3_STB, OP3_LDSB: size_of = SZ_BYTE;
         OP3_LDUH, OP3_STH, OP3_LDSH: size_of = SZ_HALF;
         OP3_LDD,  OP3_STD:           size_of = SZ_DOUBLE;
         default:                     size_of = SZ_WORD;
      endcase
   endfunction

   function automatic logic is_signed(input logic [5:0] op3);
      is_signed = (op3 == OP3_LDSB) || (op3 == OP3_LDSH);
   endfunction

   function automatic logic is_mem_op(input logic [1:0] op, input logic [5:0] op3);
      is_mem_op = (op == OP_MEM) &&
                  (op3 inside {OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_ST,
                               OP3_STB, OP3_STH, OP3_STD, OP3_LDSB, OP3_LDSH});
   endfunction

   function automatic logic is_store_op(input logic [5:0] op3);
      is_store_op = op3 inside {OP3_ST, OP3_STB, OP3_STH, OP3_STD};
   endfunction

   function automatic logic misaligned(input size_e sz, input logic [2:0] a);
      case (sz)
         SZ_HALF:   misaligned = a[0];
         SZ_WORD:   misaligned = (a[1:0] != 2'b00);
         SZ_DOUBLE: misaligned = (a != 3'b000);
         default:   misaligned = 1'b0;
      endcase
   endfunction

   // Big-endian byte enables: bit 7 covers lane [63:56], i.e. address offset 0.
   function automatic logic [7:0] lane_be(input size_e sz, input logic [2:0] a);
      case (sz)
         SZ_BYTE: lane_be = 8'h80 >> a;
         SZ_HALF: lane_be = 8'hC0 >> {a[2:1], 1'b0};
         SZ_WORD: lane_be = a[2] ? 8'h0F : 8'hF0;
         default: lane_be = 8'hFF;
      endcase
   endfunction

   function automatic logic [63:0] store_data(input size_e sz, input logic [63:0] d);
      case (sz)
         SZ_BYTE: store_data = {8{d[7:0]}};
         SZ_HALF: store_data = {4{d[15:0]}};
         SZ_WORD: store_data = {2{d[31:0]}};
         default: store_data = d;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Single-outstanding request/response data-memory bus.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic                  req_we;
   logic [DATA_W/8-1:0]   req_be;
   logic [DATA_W-1:0]     req_wdata;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_be, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_be, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/mem_load_align.sv
// Big-endian lane select and sign/zero extension of 64-bit load data.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  lane,
   input  logic [5:0]  op3,
   output logic [63:0] data_c
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] word_v;
   logic        sgn;

   // ~lane == 7-lane selects the big-endian byte/halfword position
   always_comb begin
      byte_v = rdata[{~lane, 3'b000} +: 8];
      half_v = rdata[{~lane[2:1], 4'b0000} +: 16];
      word_v = lane[2] ? rdata[31:0] : rdata[63:32];
      sgn    = is_signed(op3);
      case (size_of(op3))
         SZ_BYTE: data_c = {{56{sgn & byte_v[7]}}, byte_v};
         SZ_HALF: data_c = {{48{sgn & half_v[15]}}, half_v};
         SZ_WORD: data_c = {32'b0, word_v};
         default: data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: EX/MEM decode, bus sequencing, stall and load formatting.
// Define MEM_TIMEOUT_EN to add the REQ/WAIT timeout counter and the bus_err output.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          op,
   input  logic [5:0]          op3,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   st_data,
   input  logic [4:0]          regD_in,
   input  logic                regWrite_in,
   input  logic                regWriteDouble_in,
   output logic                mem_ready,
   mem_access_ctrl_if.master   bus,
   output logic [DATA_W-1:0]   wb_data,
   output logic [4:0]          wb_regD,
   output logic                wb_regWrite,
   output logic                wb_regWriteDouble,
   output logic                align_err
`ifdef MEM_TIMEOUT_EN
   ,
   output logic                bus_err
`endif
);

   state_e              state_q, state_d;
   logic                req_valid_q, req_valid_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic                req_we_q, req_we_d;
   logic [7:0]          req_be_q, req_be_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                mem_op;
   logic                store_op;
   logic                mis;
   size_e               size;
   logic [DATA_W-1:0]   load_data;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bus_err_q, bus_err_d;
`endif

   assign mem_op   = is_mem_op(op, op3);
   assign store_op = is_store_op(op3);
   assign size     = size_of(op3);
   assign mis      = misaligned(size, addr[2:0]);

   mem_load_align u_align (
      .rdata  (rdata_q),
      .lane   (addr[2:0]),
      .op3    (op3),
      .data_c (load_data)
   );

   // Next-state, request fields and MEM/WB outputs
   always_comb begin
      state_d     = state_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_we_d    = req_we_q;
      req_be_d    = req_be_q;
      req_wdata_d = req_wdata_q;
      rdata_d     = rdata_q;
      mem_ready   = 1'b0;
      align_err   = 1'b0;
      wb_data     = '0;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!mem_op) begin
               mem_ready = 1'b1;
               wb_data   = DATA_W'(addr);
            end else if (mis) begin
               mem_ready = 1'b1;
               align_err = 1'b1;
            end else begin
               state_d     = ST_REQ;
               req_valid_d = 1'b1;
               req_addr_d  = {addr[ADDR_W-1:3], 3'b000};
               req_we_d    = store_op;
               req_be_d    = lane_be(size, addr[2:0]);
               req_wdata_d = store_op ? store_data(size, st_data) : '0;
`ifdef MEM_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ST_REQ: begin
            if (bus.req_ready) begin
               state_d     = ST_WAIT;
               req_valid_d = 1'b0;
               req_addr_d  = '0;
               req_we_d    = 1'b0;
               req_be_d    = '0;
               req_wdata_d = '0;
            end
         end
         ST_WAIT: begin
            if (bus.resp_valid) begin
               rdata_d = bus.resp_rdata;
               state_d = ST_DONE;
            end
         end
         default: begin
            mem_ready = 1'b1;
            wb_data   = store_op ? '0 : load_data;
            state_d   = ST_IDLE;
         end
      endcase
`ifdef MEM_TIMEOUT_EN
      // A real response in the same cycle as expiry takes priority
      if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
         if ((cnt_d == CNT_W'(TIMEOUT_CYCLES)) && (state_d != ST_DONE)) begin
            state_d     = ST_DONE;
            rdata_d     = '0;
            bus_err_d   = 1'b1;
            req_valid_d = 1'b0;
            req_addr_d  = '0;
            req_we_d    = 1'b0;
            req_be_d    = '0;
            req_wdata_d = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_be_q    <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= '0;
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_we_q    <= req_we_d;
         req_be_q    <= req_be_d;
         req_wdata_q <= req_wdata_d;
         rdata_q     <= rdata_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign bus.req_valid = req_valid_q;
   assign bus.req_addr  = req_addr_q;
   assign bus.req_we    = req_we_q;
   assign bus.req_be    = req_be_q;
   assign bus.req_wdata = req_wdata_q;

   assign wb_regD           = regD_in;
   assign wb_regWrite       = regWrite_in & ~align_err;
   assign wb_regWriteDouble = regWriteDouble_in & ~align_err;

`ifdef MEM_TIMEOUT_EN
   assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (timeout case runs when MEM_TIMEOUT_EN is defined).
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic [1:0]  op;
   logic [5:0]  op3;
   logic [31:0] addr;
   logic [63:0] st_data;
   logic [4:0]  regD_in;
   logic        regWrite_in;
   logic        regWriteDouble_in;
   logic        mem_ready;
   logic [63:0] wb_data;
   logic [4:0]  wb_regD;
   logic        wb_regWrite;
   logic        wb_regWriteDouble;
   logic        align_err;
`ifdef MEM_TIMEOUT_EN
   logic        bus_err;
`endif

   int checks;
   int failures;

   mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(64)) bus ();

   mem_access_ctrl #(
      .ADDR_W(32),
      .DATA_W(64)
`ifdef MEM_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(4)
`endif
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .op                (op),
      .op3               (op3),
      .addr              (addr),
      .st_data           (st_data),
      .regD_in           (regD_in),
      .regWrite_in       (regWrite_in),
      .regWriteDouble_in (regWriteDouble_in),
      .mem_ready         (mem_ready),
      .bus               (bus),
      .wb_data           (wb_data),
      .wb_regD           (wb_regD),
      .wb_regWrite       (wb_regWrite),
      .wb_regWriteDouble (wb_regWriteDouble),
      .align_err         (align_err)
`ifdef MEM_TIMEOUT_EN
      ,
      .bus_err           (bus_err)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Aligned load with immediate req_ready and one-cycle response latency
   task automatic run_load(input logic [5:0] o3, input logic [31:0] a,
                           input logic [63:0] rd, input logic [63:0] exp, input string tag);
      op = 2'b11; op3 = o3; addr = a;
      #1;
      chk({tag, "_idle_stall"}, 64'(mem_ready), 64'd0);
      tick();
      chk({tag, "_req_valid"}, 64'(bus.req_valid), 64'd1);
      chk({tag, "_req_we"}, 64'(bus.req_we), 64'd0);
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_rdata = rd;
      tick();
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
      #1;
      chk({tag, "_done_ready"}, 64'(mem_ready), 64'd1);
      chk({tag, "_wb_data"}, wb_data, exp);
      op = 2'b10;
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      op = 2'b00; op3 = 6'd0; addr = 32'd0; st_data = 64'd0;
      regD_in = 5'd0; regWrite_in = 1'b0; regWriteDouble_in = 1'b0;
      bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = 64'd0;
      tick();
      tick();

      chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
      chk("rst_req_we",    64'(bus.req_we),    64'd0);
      chk("rst_req_be",    64'(bus.req_be),    64'd0);
      chk("rst_req_addr",  64'(bus.req_addr),  64'd0);
      chk("rst_req_wdata", bus.req_wdata,      64'd0);
      chk("rst_align_err", 64'(align_err),     64'd0);
`ifdef MEM_TIMEOUT_EN
      chk("rst_bus_err",   64'(bus_err),       64'd0);
`endif
      reset = 1'b0;

      // Non-memory op passes the ALU result straight through
      op = 2'b10; op3 = 6'b000000; addr = 32'h1234;
      regD_in = 5'd7; regWrite_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("nonmem_ready", 64'(mem_ready),     64'd1);
         chk("nonmem_valid", 64'(bus.req_valid), 64'd0);
         chk("nonmem_wb",    wb_data,            64'h1234);
         tick();
      end
      chk("nonmem_regD", 64'(wb_regD),     64'd7);
      chk("nonmem_we",   64'(wb_regWrite), 64'd1);

      // LDSB 0x1003 with req_ready held low for two REQ cycles
      op = 2'b11; op3 = 6'b001001; addr = 32'h1003; regD_in = 5'd5;
      #1;
      chk("ldsb_idle_stall", 64'(mem_ready), 64'd0);
      chk("ldsb_align",      64'(align_err), 64'd0);
      tick();
      chk("ldsb_req_valid", 64'(bus.req_valid), 64'd1);
      chk("ldsb_req_addr",  64'(bus.req_addr),  64'h1000);
      chk("ldsb_req_be",    64'(bus.req_be),    64'h10);
      chk("ldsb_req_stall", 64'(mem_ready),     64'd0);
      tick();
      chk("ldsb_hold_valid", 64'(bus.req_valid), 64'd1);
      chk("ldsb_hold_addr",  64'(bus.req_addr),  64'h1000);
      bus.resp_valid = 1'b1;
      bus.resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      bus.resp_valid = 1'b0;
      chk("ldsb_early_resp", 64'(mem_ready),     64'd0);
      chk("ldsb_hold2",      64'(bus.req_valid), 64'd1);
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      #1;
      chk("ldsb_wait_valid", 64'(bus.req_valid), 64'd0);
      chk("ldsb_wait_stall", 64'(mem_ready),     64'd0);
      tick();
      chk("ldsb_wait_stall2", 64'(mem_ready), 64'd0);
      bus.resp_valid = 1'b1;
      bus.resp_rdata = 64'h0011_2233_8055_6677;
      tick();
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 64'd0;
      #1;
      chk("ldsb_done_ready", 64'(mem_ready),   64'd1);
      chk("ldsb_wb",         wb_data,          64'h0000_0000_0000_0033);
      chk("ldsb_wb_regD",    64'(wb_regD),     64'd5);
      chk("ldsb_wb_we",      64'(wb_regWrite), 64'd1);
      op = 2'b10;
      tick();

      run_load(6'b001001, 32'h1004, 64'h0011_2233_8055_6677, 64'hFFFF_FFFF_FFFF_FF80, "ldsb_neg");
      run_load(6'b000010, 32'h1006, 64'h0011_2233_8055_6677, 64'h0000_0000_0000_6677, "lduh");
      run_load(6'b001010, 32'h1004, 64'h0011_2233_8055_6677, 64'hFFFF_FFFF_FFFF_8055, "ldsh");
      run_load(6'b000000, 32'h1004, 64'h0011_2233_8055_6677, 64'h0000_0000_8055_6677, "ld");
      run_load(6'b000001, 32'h1004, 64'h0011_2233_8055_6677, 64'h0000_0000_0000_0080, "ldub");
      run_load(6'b000011, 32'h1008, 64'h0011_2233_8055_6677, 64'h0011_2233_8055_6677, "ldd");

      // ST at 0x2004: upper-word lane, replicated data
      op = 2'b11; op3 = 6'b000100; addr = 32'h2004; st_data = 64'h1111_1111_DEAD_BEEF;
      tick();
      chk("st_req_addr",  64'(bus.req_addr), 64'h2000);
      chk("st_req_be",    64'(bus.req_be),   64'h0F);
      chk("st_req_wdata", bus.req_wdata,     64'hDEAD_BEEF_DEAD_BEEF);
      chk("st_req_we",    64'(bus.req_we),   64'd1);
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b1;
      tick();
      bus.resp_valid = 1'b0;
      chk("st_done_ready", 64'(mem_ready), 64'd1);
      chk("st_done_wb",    wb_data,        64'd0);
      tick();
      chk("st_one_done", 64'(mem_ready), 64'd0);
      op = 2'b10;
      tick();

      // STB at 0x2005: one-hot enable at lane 5
      op = 2'b11; op3 = 6'b000101; addr = 32'h2005;
      tick();
      chk("stb_req_be",    64'(bus.req_be), 64'h04);
      chk("stb_req_wdata", bus.req_wdata,   64'hEFEF_EFEF_EFEF_EFEF);
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b1;
      tick();
      bus.resp_valid = 1'b0;
      op = 2'b10;
      tick();

      // Misaligned LDD and LDUH: no bus access, write enables dropped
      op = 2'b11; op3 = 6'b000011; addr = 32'h3004;
      regWrite_in = 1'b1; regWriteDouble_in = 1'b1;
      #1;
      chk("ldd_mis_align", 64'(align_err),         64'd1);
      chk("ldd_mis_ready", 64'(mem_ready),         64'd1);
      chk("ldd_mis_we",    64'(wb_regWrite),       64'd0);
      chk("ldd_mis_wed",   64'(wb_regWriteDouble), 64'd0);
      tick();
      chk("ldd_mis_noreq", 64'(bus.req_valid), 64'd0);
      op3 = 6'b000010; addr = 32'h3001;
      #1;
      chk("lduh_mis_align", 64'(align_err), 64'd1);
      tick();
      chk("lduh_mis_noreq", 64'(bus.req_valid), 64'd0);
      regWriteDouble_in = 1'b0;

      // Reset during WAIT, then a late response must be ignored
      op3 = 6'b000000; addr = 32'h4000;
      tick();
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      op = 2'b10; addr = 32'h4444;
      #1;
      chk("rstw_ready", 64'(mem_ready),     64'd1);
      chk("rstw_valid", 64'(bus.req_valid), 64'd0);
      chk("rstw_we",    64'(bus.req_we),    64'd0);
      chk("rstw_be",    64'(bus.req_be),    64'd0);
      chk("rstw_addr",  64'(bus.req_addr),  64'd0);
      chk("rstw_wdata", bus.req_wdata,      64'd0);
      bus.resp_valid = 1'b1;
      bus.resp_rdata = 64'h1234_5678_9ABC_DEF0;
      tick();
      bus.resp_valid = 1'b0;
      tick();
      chk("late_resp_ready", 64'(mem_ready),     64'd1);
      chk("late_resp_valid", 64'(bus.req_valid), 64'd0);
      chk("late_resp_wb",    wb_data,            64'h4444);

`ifdef MEM_TIMEOUT_EN
      // No response: DONE after four REQ/WAIT cycles with bus_err and zero data
      op = 2'b11; op3 = 6'b000000; addr = 32'h5000;
      tick();
      bus.req_ready = 1'b1;
      tick();
      bus.req_ready = 1'b0;
      tick();
      tick();
      chk("to_stall", 64'(mem_ready), 64'd0);
      tick();
      chk("to_done_ready", 64'(mem_ready), 64'd1);
      chk("to_bus_err",    64'(bus_err),   64'd1);
      chk("to_wb",         wb_data,        64'd0);
      op = 2'b10;
      tick();
      chk("to_bus_err_clr", 64'(bus_err), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
